// File: rtl/apb_master.sv
// Single-outstanding APB requester: takes one command over valid/ready, runs the
// APB SETUP/ACCESS handshake with an optional wait-state timeout, returns one response.
module apb_master #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              p_sel,
    output logic              p_en,
    output logic              p_write,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              p_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // TIMEOUT=0 still needs a 1-bit counter so the saturating logic has something to hold.
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    // NOTE: every register lives in this one clocked block and uses <= so all
    // updates see the pre-edge values; the reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            p_write   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state    <= SETUP;
                        p_sel    <= 1'b1;
                        p_write  <= cmd_write;
                        addr     <= cmd_addr;
                        wdata    <= cmd_wdata;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    p_en  <= 1'b1;
                end
                ACCESS: begin
                    if (p_ready) begin
                        state     <= RESP;
                        p_sel     <= 1'b0;
                        p_en      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= p_write ? '0 : rdata;
                        rsp_err   <= 1'b0;
                    end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
                        // This stalled cycle brings the count to TIMEOUT: abandon the transfer.
                        state     <= RESP;
                        wait_cnt  <= wait_cnt + 1'b1;
                        p_sel     <= 1'b0;
                        p_en      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a wait-state-programmable APB slave model plus a word-array
// reference memory that predicts every response, latency and error flag.
module tb_apb_master;

    localparam int AWIDTH  = 8;
    localparam int DWIDTH  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              p_sel;
    logic              p_en;
    logic              p_write;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic              p_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_master #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .p_sel(p_sel), .p_en(p_en), .p_write(p_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .p_ready(p_ready)
    );

    always #5 clk = ~clk;

    // Slave model: registered p_ready, slv_waits extra wait states, or never ready when stalled.
    logic [DWIDTH-1:0] slv_mem [256];
    int unsigned       slv_waits = 0;
    bit                slv_stall = 1'b0;
    int unsigned       slv_cnt   = 0;

    assign rdata = slv_mem[addr];

    always @(posedge clk) begin
        if (p_sel && p_en && p_ready) begin
            if (p_write) slv_mem[addr] <= wdata;
            p_ready <= 1'b0;
        end else if (p_sel && p_en) begin
            if (!slv_stall && slv_cnt == 0) p_ready <= 1'b1;
            else if (slv_cnt != 0) slv_cnt <= slv_cnt - 1;
        end else begin
            p_ready <= 1'b0;
            slv_cnt <= slv_waits;
        end
    end

    // Reference memory: what a read of each address must return.
    logic [DWIDTH-1:0] ref_mem [256];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one full command/response exchange; starts and ends on a negedge.
    task automatic do_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input int waits, input bit stall, input string tag);
        int n;
        int acc;
        int lat;
        logic [31:0] exp_rdata;
        int exp_acc;
        exp_rdata = (wr || stall) ? 32'h0 : ref_mem[a];
        exp_acc   = stall ? TIMEOUT : waits + 2;
        slv_waits = waits;
        slv_stall = stall;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: cmd_ready=%b expected 1", tag, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if ({p_sel, p_en, p_write, addr, wdata, busy} !== {1'b1, 1'b0, wr, a, d, 1'b1}) begin
            bad++;
            $display("FAIL %s setup: sel=%b en=%b wr=%b addr=%h wdata=%h busy=%b expected 1 0 %b %h %h 1",
                     tag, p_sel, p_en, p_write, addr, wdata, busy, wr, a, d);
        end
        @(negedge clk);
        lat = 2;
        acc = 0;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            acc++;
            total++;
            if ({p_sel, p_en, p_write, addr, wdata} !== {1'b1, 1'b1, wr, a, d}) begin
                bad++;
                $display("FAIL %s access: sel=%b en=%b wr=%b addr=%h wdata=%h expected 1 1 %b %h %h",
                         tag, p_sel, p_en, p_write, addr, wdata, wr, a, d);
            end
            @(negedge clk);
            lat++;
        end
        total++;
        if (rsp_valid !== 1'b1 || acc != exp_acc || lat != exp_acc + 2) begin
            bad++;
            $display("FAIL %s timing: rsp_valid=%b access_cycles=%0d latency=%0d expected 1 %0d %0d",
                     tag, rsp_valid, acc, lat, exp_acc, exp_acc + 2);
        end
        total++;
        if ({rsp_err, rsp_rdata} !== {stall, exp_rdata}) begin
            bad++;
            $display("FAIL %s response: err=%b rdata=%h expected %b %h", tag, rsp_err, rsp_rdata, stall, exp_rdata);
        end
        total++;
        if ({p_sel, p_en, cmd_ready, busy} !== 4'b0001) begin
            bad++;
            $display("FAIL %s resp_state: sel=%b en=%b cmd_ready=%b busy=%b expected 0 0 0 1",
                     tag, p_sel, p_en, cmd_ready, busy);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL %s release: rsp_valid=%b cmd_ready=%b busy=%b expected 0 1 0",
                     tag, rsp_valid, cmd_ready, busy);
        end
        if (wr && !stall) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({p_sel, p_en, p_write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy, cmd_ready} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: sel=%b en=%b wr=%b addr=%h wdata=%h rv=%b rd=%h err=%b busy=%b cmd_ready=%b expected all 0, cmd_ready=1",
                     p_sel, p_en, p_write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy, cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, "write_0x10");
        do_txn(1'b0, 8'h10, 32'h0, 0, 1'b0, "read_0x10");
        do_txn(1'b0, 8'h10, 32'h0, 3, 1'b0, "read_0x10_waits");
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 8'h30, 32'h12345678, 0, 1'b1, "timeout_write");
        do_txn(1'b0, 8'h10, 32'h0, 0, 1'b1, "timeout_read");
        do_txn(1'b0, 8'h30, 32'h0, 1, 1'b0, "after_timeout_read");
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] exp_rdata;
        exp_rdata = ref_mem[8'h10];
        slv_waits = 0;
        slv_stall = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_wdata = 32'h0;
        cmd_valid = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, p_sel} !== {1'b1, exp_rdata, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_resp[%0d]: rv=%b rd=%h err=%b cmd_ready=%b sel=%b expected 1 %h 0 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, p_sel, exp_rdata);
            end
            if (i < 5) @(negedge clk);
        end
        rsp_ready = 1'b1;
        cmd_addr  = 8'h20;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, p_sel} !== 3'b010) begin
            bad++;
            $display("FAIL hold_release: rv=%b cmd_ready=%b sel=%b expected 0 1 0", rsp_valid, cmd_ready, p_sel);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if ({p_sel, p_en, addr} !== {1'b1, 1'b0, 8'h20}) begin
            bad++;
            $display("FAIL hold_next_setup: sel=%b en=%b addr=%h expected 1 0 20", p_sel, p_en, addr);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, ref_mem[8'h20]}) begin
            bad++;
            $display("FAIL hold_next_resp: rv=%b rd=%h expected 1 %h", rsp_valid, rsp_rdata, ref_mem[8'h20]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_access();
        int n;
        slv_waits = 2;
        slv_stall = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_valid = 1'b1;
        n = 0;
        while (p_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            if (p_sel === 1'b1) cmd_valid = 1'b0;
            n++;
        end
        cmd_valid = 1'b0;
        total++;
        if (p_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach_access: en=%b expected 1", p_en);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if ({p_sel, p_en, p_write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy, cmd_ready} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_state: sel=%b en=%b wr=%b addr=%h wdata=%h rv=%b rd=%h err=%b busy=%b cmd_ready=%b expected all 0, cmd_ready=1",
                     p_sel, p_en, p_write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy, cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, p_sel, busy} !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid_quiet[%0d]: rv=%b sel=%b busy=%b expected 0 0 0", i, rsp_valid, p_sel, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 8'hFF, 32'hFFFFFFFF, 0, 1'b0, "b2b_write_ff");
        do_txn(1'b1, 8'h00, 32'h00000001, 0, 1'b0, "b2b_write_00");
        do_txn(1'b0, 8'hFF, 32'h0, 0, 1'b0, "b2b_read_ff");
        do_txn(1'b0, 8'h00, 32'h0, 0, 1'b0, "b2b_read_00");
    endtask

    task automatic test_random();
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            if (i % 3 == 0) a = 8'($urandom_range(0, 3));
            d  = $urandom;
            do_txn(wr, a, d, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_timeout();
        test_backpressure();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
